shadowmask_ctrl: RTL and testbench
==================================

Name: shadowmask_ctrl

Overview:
Runtime controller for the shadow-mask pixel stage. Holds a host-programmable, double-buffered mask pattern (up to 8x4 cells of 3-bit R/G/B enables). Tracks the pixel phase from hs/vs and emits per-pixel mask bits plus an enable, aligned with delayed sync/de, to the mask datapath. A host commit swaps the shadow pattern in at the next frame start, so the mask never changes mid-frame.

Parameters:
HBITS, 3, column index width; pattern width 1..2^HBITS
VBITS, 2, row index width; pattern height 1..2^VBITS

Ports:
clk  in  1  pixel clock
reset  in  1  asynchronous, active-high reset
wr_en  in  1  host write strobe, one entry per cycle
wr_addr  in  6  [5]=0: pattern cell {row[4:3],col[2:0]}; 6'h20: geometry register; other addresses ignored
wr_data  in  8  cell: [2:0]=RGB enables; geometry: [2:0]=width-1, [4:3]=height-1
commit  in  1  single-cycle request to swap the shadow bank to active
enable  in  1  host mask on/off, sampled every cycle
hs_in, vs_in, de_in  in  1 each  video timing, active-high sync
mask_rgb  out  3  {r,g,b} enable bits for the current pixel
mask_en  out  1  datapath applies the mask when 1
hs_out, vs_out, de_out  out  1 each  timing delayed to align with mask_rgb
pending  out  1  commit accepted, swap not yet done; host writes rejected

Behaviour:
- Reset (async, any time): all outputs 0; pending=0; active_valid=0; hcount=vcount=0; active bank index 0; both geometries = width 1, height 1. Pattern RAM contents are not reset.
- Storage: two banks of 32x3 cells plus a geometry register per bank. Host writes go only to the shadow bank (~active). The datapath reads only the active bank.
- Write rules: a write is accepted when wr_en=1 and pending=0. While pending=1, writes are dropped silently. Unmapped addresses are dropped.
- Edge detect: old_hs/old_vs registered every cycle. hs_fall = old_hs & ~hs_in; vs_fall = old_vs & ~vs_in.
- hcount: on hs_fall -> 0. Else if hcount==width-1 -> 0. Else +1. Counts every clock, not just de.
- vcount: on vs_fall -> 0 (vs_fall takes priority over hs_fall). Else on hs_fall -> if vcount==height-1 then 0, else +1.
- Width/height come from the active geometry. A geometry value smaller than a current count takes effect at the next wrap or sync.
- State machine:
  - IDLE: commit=1 -> PEND (pending=1).
  - PEND: vs_fall -> SWAP. Further commits are ignored.
  - SWAP (one cycle): flip the active bank, active_valid=1, counters zeroed, -> IDLE (pending=0).
- commit and vs_fall in the same cycle: the swap waits for the following vs_fall.
- Output stage, registered, latency 1 clock:
  - mask_rgb = active_bank[{vcount,hcount}]
  - mask_en = enable & active_valid
  - hs_out/vs_out/de_out = hs_in/vs_in/de_in delayed by 1 clock
- The pattern RAM read is asynchronous (LUT-based); total pipeline depth is exactly 1.
- mask_rgb is forced to 0 whenever mask_en would be 0.

Decomposition:
- Package shadowmask_pkg:
  - ctrl_state_t enum {IDLE, PEND, SWAP}
  - GEOM_ADDR = 6'h20
  - RGB bit constants R=3'b100, G=3'b010, B=3'b001
- Sub-module shadowmask_bank: one 32x3 bank plus geometry register, with a write port and a combinational read port. Instantiated twice.

Test Plan:
- Reset mid-frame with a valid mask active -> all outputs 0 on the next edge; pending=0; mask_en stays 0 until a new commit and vs_fall.
- Write geometry 8'h05 (width 6, height 1) and cells 0..5 = 4,4,2,2,1,1; commit; vs_fall; enable=1 -> mask_rgb sequence 4,4,2,2,1,1 repeating, restarting at 4 one clock after each hs_fall.
- Geometry 8'h1D (width 6, height 4), rows 0/1 = 4,4,2,2,1,1 and rows 2/3 = 2,1,1,4,4,2 -> line 2 after vs_fall starts with 2; line 4 returns to row 0.
- Commit, then write cell 0=7 while pending -> the write is dropped; after the swap cell 0 reads the previously written value.
- commit and vs_fall in the same cycle -> pending=1 through that frame; swap at the next vs_fall; pending drops one cycle after it.
- enable toggled 1->0 mid-line -> mask_en=0 and mask_rgb=0 on the following clock; hs/vs/de_out remain exactly 1 clock behind the inputs.

Source files
------------

// File: rtl/shadowmask_pkg.sv
// Shared types and constants for the shadow-mask runtime controller.
package shadowmask_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PEND,
        SWAP
    } ctrl_state_t;

    localparam logic [5:0] GEOM_ADDR = 6'h20;

    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] G = 3'b010;
    localparam logic [2:0] B = 3'b001;

endpackage

// File: rtl/shadowmask_bank.sv
// One pattern bank: 2^(HBITS+VBITS) cells of RGB enables plus its geometry register.
module shadowmask_bank #(
    parameter int HBITS = 3,
    parameter int VBITS = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   we_cell,
    input  logic                   we_geom,
    input  logic [HBITS+VBITS-1:0] wr_idx,
    input  logic [4:0]             wr_data,
    input  logic [HBITS+VBITS-1:0] rd_idx,
    output logic [2:0]             rd_rgb,
    output logic [HBITS-1:0]       width_m1,
    output logic [VBITS-1:0]       height_m1
);

    localparam int DEPTH = 1 << (HBITS + VBITS);

    // Pattern cells are deliberately left unreset so they map onto LUT RAM.
    logic [2:0] cells [DEPTH];

    always_ff @(posedge clk) begin
        if (we_cell) begin
            cells[wr_idx] <= wr_data[2:0];
        end
    end

    assign rd_rgb = cells[rd_idx];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            width_m1  <= '0;
            height_m1 <= '0;
        end else if (we_geom) begin
            width_m1  <= wr_data[HBITS-1:0];
            height_m1 <= wr_data[3 +: VBITS];
        end
    end

endmodule

// File: rtl/shadowmask_ctrl.sv
// Shadow-mask runtime controller: double-buffered pattern, pixel phase tracking,
// frame-synchronous bank swap and a single registered output stage.
module shadowmask_ctrl #(
    parameter int HBITS = 3,
    parameter int VBITS = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [5:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic       commit,
    input  logic       enable,
    input  logic       hs_in,
    input  logic       vs_in,
    input  logic       de_in,
    output logic [2:0] mask_rgb,
    output logic       mask_en,
    output logic       hs_out,
    output logic       vs_out,
    output logic       de_out,
    output logic       pending
);

    import shadowmask_pkg::*;

    localparam int AW = HBITS + VBITS;

    ctrl_state_t      state;
    logic             active_bank;
    logic             active_valid;
    logic             old_hs;
    logic             old_vs;
    logic             hs_fall;
    logic             vs_fall;
    logic [HBITS-1:0] hcount;
    logic [VBITS-1:0] vcount;

    logic             wr_ok;
    logic             we_cell;
    logic             we_geom;
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    rd_idx;

    logic [2:0]       rgb_b0;
    logic [2:0]       rgb_b1;
    logic [HBITS-1:0] wm1_b0;
    logic [HBITS-1:0] wm1_b1;
    logic [VBITS-1:0] hm1_b0;
    logic [VBITS-1:0] hm1_b1;

    logic [2:0]       act_rgb;
    logic [HBITS-1:0] width_m1;
    logic [VBITS-1:0] height_m1;
    logic             en_next;
    logic             unused_wr_bits;

    assign hs_fall = old_hs & ~hs_in;
    assign vs_fall = old_vs & ~vs_in;

    assign wr_ok   = wr_en & ~pending;
    assign we_cell = wr_ok & ~wr_addr[5];
    assign we_geom = wr_ok & (wr_addr == GEOM_ADDR);
    assign wr_idx  = {wr_addr[3 +: VBITS], wr_addr[0 +: HBITS]};
    assign rd_idx  = {vcount, hcount};

    assign unused_wr_bits = ^wr_data[7:5];

    // Host writes only ever land in the bank that is not being displayed.
    shadowmask_bank #(.HBITS(HBITS), .VBITS(VBITS)) u_bank0 (
        .clk       (clk),
        .reset     (reset),
        .we_cell   (we_cell & active_bank),
        .we_geom   (we_geom & active_bank),
        .wr_idx    (wr_idx),
        .wr_data   (wr_data[4:0]),
        .rd_idx    (rd_idx),
        .rd_rgb    (rgb_b0),
        .width_m1  (wm1_b0),
        .height_m1 (hm1_b0)
    );

    shadowmask_bank #(.HBITS(HBITS), .VBITS(VBITS)) u_bank1 (
        .clk       (clk),
        .reset     (reset),
        .we_cell   (we_cell & ~active_bank),
        .we_geom   (we_geom & ~active_bank),
        .wr_idx    (wr_idx),
        .wr_data   (wr_data[4:0]),
        .rd_idx    (rd_idx),
        .rd_rgb    (rgb_b1),
        .width_m1  (wm1_b1),
        .height_m1 (hm1_b1)
    );

    assign act_rgb   = active_bank ? rgb_b1 : rgb_b0;
    assign width_m1  = active_bank ? wm1_b1 : wm1_b0;
    assign height_m1 = active_bank ? hm1_b1 : hm1_b0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            pending      <= 1'b0;
            active_bank  <= 1'b0;
            active_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (commit) begin
                        state   <= PEND;
                        pending <= 1'b1;
                    end
                end
                PEND: begin
                    if (vs_fall) begin
                        state <= SWAP;
                    end
                end
                SWAP: begin
                    active_bank  <= ~active_bank;
                    active_valid <= 1'b1;
                    pending      <= 1'b0;
                    state        <= IDLE;
                end
                default: begin
                    state   <= IDLE;
                    pending <= 1'b0;
                end
            endcase
        end
    end

    // A shrunken geometry only bites at the next wrap/sync; counts past it roll over.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            old_hs <= 1'b0;
            old_vs <= 1'b0;
            hcount <= '0;
            vcount <= '0;
        end else begin
            old_hs <= hs_in;
            old_vs <= vs_in;
            if (state == SWAP) begin
                hcount <= '0;
                vcount <= '0;
            end else begin
                if (hs_fall || hcount == width_m1) begin
                    hcount <= '0;
                end else begin
                    hcount <= hcount + 1'b1;
                end
                if (vs_fall) begin
                    vcount <= '0;
                end else if (hs_fall) begin
                    vcount <= (vcount == height_m1) ? '0 : vcount + 1'b1;
                end
            end
        end
    end

    assign en_next = enable & active_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mask_rgb <= '0;
            mask_en  <= 1'b0;
            hs_out   <= 1'b0;
            vs_out   <= 1'b0;
            de_out   <= 1'b0;
        end else begin
            mask_rgb <= en_next ? act_rgb : '0;
            mask_en  <= en_next;
            hs_out   <= hs_in;
            vs_out   <= vs_in;
            de_out   <= de_in;
        end
    end

endmodule

// File: tb/tb_shadowmask_ctrl.sv
// Scoreboard bench for shadowmask_ctrl: directed frames push expected pixels,
// a monitor pops them whenever de_out is high and checks sync alignment each cycle.
module tb_shadowmask_ctrl;

    import shadowmask_pkg::*;

    logic       clk     = 1'b0;
    logic       reset   = 1'b0;
    logic       wr_en   = 1'b0;
    logic [5:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic       commit  = 1'b0;
    logic       enable  = 1'b0;
    logic       hs_in   = 1'b0;
    logic       vs_in   = 1'b0;
    logic       de_in   = 1'b0;
    logic [2:0] mask_rgb;
    logic       mask_en;
    logic       hs_out;
    logic       vs_out;
    logic       de_out;
    logic       pending;

    int n_checks = 0;
    int n_fail   = 0;
    logic [3:0] exp_q [$];
    logic valid_flag = 1'b0;

    localparam logic [17:0] ROW_A = {R, R, G, G, B, B};
    localparam logic [17:0] ROW_B = {G, B, B, R, R, G};

    shadowmask_ctrl #(.HBITS(3), .VBITS(2)) dut (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .commit   (commit),
        .enable   (enable),
        .hs_in    (hs_in),
        .vs_in    (vs_in),
        .de_in    (de_in),
        .mask_rgb (mask_rgb),
        .mask_en  (mask_en),
        .hs_out   (hs_out),
        .vs_out   (vs_out),
        .de_out   (de_out),
        .pending  (pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [2:0] cell_of(input logic [17:0] pat, input int k);
        return pat[17 - 3 * k -: 3];
    endfunction

    // Monitor: sync delay every cycle, pixel scoreboard whenever de_out is high.
    initial begin
        logic h;
        logic v;
        logic d;
        logic [3:0] e;
        forever begin
            @(posedge clk);
            h = hs_in;
            v = vs_in;
            d = de_in;
            #1;
            if (!reset) begin
                check("hs_out_delay", 8'(hs_out), 8'(h));
                check("vs_out_delay", 8'(vs_out), 8'(v));
                check("de_out_delay", 8'(de_out), 8'(d));
                if (de_out) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL pixel: de_out high with no expected pixel queued at %0t", $time);
                    end else begin
                        e = exp_q.pop_front();
                        check("pixel_en_rgb", 8'({mask_en, mask_rgb}), 8'(e));
                    end
                end
            end
        end
    end

    task automatic wr(input logic [5:0] a, input logic [7:0] d);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic do_commit();
        @(negedge clk);
        commit = 1'b1;
        @(negedge clk);
        commit = 1'b0;
    endtask

    task automatic frame_start(input logic c, output logic pend_mid);
        @(negedge clk);
        vs_in = 1'b1;
        hs_in = 1'b1;
        de_in = 1'b0;
        @(negedge clk);
        vs_in  = 1'b0;
        hs_in  = 1'b0;
        commit = c;
        @(negedge clk);
        commit   = 1'b0;
        pend_mid = pending;
        @(negedge clk);
    endtask

    task automatic line(input logic [17:0] pat, input int npix, input int en_off);
        logic en;
        @(negedge clk);
        hs_in = 1'b1;
        de_in = 1'b0;
        @(negedge clk);
        hs_in = 1'b0;
        for (int i = 0; i < npix; i++) begin
            @(negedge clk);
            de_in  = 1'b1;
            enable = (i < en_off);
            en     = enable & valid_flag;
            exp_q.push_back({en, en ? cell_of(pat, i % 6) : 3'b000});
        end
        @(negedge clk);
        de_in  = 1'b0;
        enable = 1'b1;
    endtask

    initial begin
        logic pm;
        #1 reset = 1'b1;
        #1;
        check("rst_mask_rgb", 8'(mask_rgb), 8'h0);
        check("rst_mask_en",  8'(mask_en),  8'h0);
        check("rst_hs_out",   8'(hs_out),   8'h0);
        check("rst_vs_out",   8'(vs_out),   8'h0);
        check("rst_de_out",   8'(de_out),   8'h0);
        check("rst_pending",  8'(pending),  8'h0);
        @(negedge clk);
        @(negedge clk);
        reset  = 1'b0;
        enable = 1'b1;

        // No committed pattern yet: mask stays off.
        frame_start(1'b0, pm);
        line(ROW_A, 6, 99);
        check("pending_idle", 8'(pending), 8'h0);

        // Width 6, height 1 pattern into the shadow bank.
        wr(GEOM_ADDR, 8'h05);
        for (int k = 0; k < 6; k++) begin
            wr(6'(k), {5'b0, cell_of(ROW_A, k)});
        end
        do_commit();
        check("pending_after_commit", 8'(pending), 8'h1);
        wr(6'h00, 8'h07);
        frame_start(1'b0, pm);
        check("pending_swap_cycle", 8'(pm), 8'h1);
        check("pending_after_swap", 8'(pending), 8'h0);
        valid_flag = 1'b1;
        line(ROW_A, 12, 99);
        line(ROW_A, 8, 99);
        line(ROW_A, 6, 3);

        // Width 6, height 4 pattern; commit coincides with vs_fall.
        wr(GEOM_ADDR, 8'h1D);
        wr(6'h21, 8'h00);
        wr(6'h3F, 8'h00);
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 6; c++) begin
                wr(6'(r * 8 + c), {5'b0, cell_of((r < 2) ? ROW_A : ROW_B, c)});
            end
        end
        frame_start(1'b1, pm);
        check("pending_commit_at_vsfall", 8'(pm), 8'h1);
        check("pending_same_frame", 8'(pending), 8'h1);
        line(ROW_A, 6, 99);
        check("pending_through_frame", 8'(pending), 8'h1);
        frame_start(1'b0, pm);
        check("pending_swap2_cycle", 8'(pm), 8'h1);
        check("pending_after_swap2", 8'(pending), 8'h0);
        line(ROW_A, 6, 99);
        line(ROW_B, 8, 99);
        line(ROW_B, 6, 99);
        line(ROW_A, 6, 99);

        // Asynchronous reset mid-frame while the mask is live.
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("midrst_mask_en",  8'(mask_en),  8'h0);
        check("midrst_mask_rgb", 8'(mask_rgb), 8'h0);
        check("midrst_pending",  8'(pending),  8'h0);
        @(negedge clk);
        reset      = 1'b0;
        valid_flag = 1'b0;
        check("postrst_hs_out", 8'(hs_out), 8'h0);
        frame_start(1'b0, pm);
        line(ROW_A, 6, 99);
        check("postrst_pending", 8'(pending), 8'h0);

        repeat (3) @(negedge clk);
        check("queue_drained", 8'(exp_q.size()), 8'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
